// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
//   Shared types for the data-memory arbiter: the memory access size/sign
//   encoding used by the CPU, debug port and data_memory, the arbiter
//   ownership state, and a helper that sizes the arbiter's saturating
//   counters from their maximum values.
package dmem_arbiter_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_op_t;

  typedef enum logic {
    CPU_OWN = 1'b0,
    DBG_OWN = 1'b1
  } dmem_arb_state_t;

  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_MAX_BURST    = 2;

  // Bits needed to hold 0..max_val inclusive, never less than one bit.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int WAIT_CNT_W  = cnt_width(DEF_STARVE_LIMIT);
  localparam int BURST_CNT_W = cnt_width(DEF_MAX_BURST);

endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single data_memory port between the CPU MEM stage and a
//   debug/loader port. The CPU normally has priority and debug fills idle
//   slots; after STARVE_LIMIT consecutive denied debug cycles, debug owns the
//   port for up to MAX_BURST grants while the CPU is stalled.
//
//   Ports
//     clk, reset                     clock, synchronous active-high reset
//     cpu_req/wr_en/op/addr/wdata    CPU MEM stage access
//     cpu_rdata, cpu_stall           CPU load data (combinational), stall
//     dbg_valid/wr_en/op/addr/wdata  debug request (held until dbg_ready)
//     dbg_ready                      debug request accepted this cycle
//     dbg_rdata, dbg_rvalid          registered debug read data, 1-cycle pulse
//     mem_wr_en/op/addr/data_in      to data_memory
//     mem_data_out                   from data_memory (combinational read)
//
//   state   | meaning
//   CPU_OWN | CPU has priority; debug only gets cycles with no cpu_req
//   DBG_OWN | debug has priority for at most MAX_BURST grants
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int MAX_BURST    = DEF_MAX_BURST
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_wr_en,
  input  mem_op_t     cpu_op,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dbg_valid,
  output logic        dbg_ready,
  input  logic        dbg_wr_en,
  input  mem_op_t     dbg_op,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        dbg_rvalid,
  output logic        mem_wr_en,
  output mem_op_t     mem_op,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  localparam int WAIT_W  = cnt_width(STARVE_LIMIT);
  localparam int BURST_W = cnt_width(MAX_BURST);

  localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(STARVE_LIMIT);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(STARVE_LIMIT - 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

  dmem_arb_state_t     r_st;
  dmem_arb_state_t     w_st_next;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [WAIT_W-1:0]   w_wait_next;
  logic [BURST_W-1:0]  r_burst_cnt;
  logic [BURST_W-1:0]  w_burst_next;
  logic [31:0]         r_dbg_rdata;
  logic                r_dbg_rvalid;
  logic                w_cpu_grant;
  logic                w_dbg_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_st         <= CPU_OWN;
      r_wait_cnt   <= '0;
      r_burst_cnt  <= '0;
      r_dbg_rdata  <= '0;
      r_dbg_rvalid <= 1'b0;
    end else begin
      r_st         <= w_st_next;
      r_wait_cnt   <= w_wait_next;
      r_burst_cnt  <= w_burst_next;
      r_dbg_rvalid <= w_dbg_grant && !dbg_wr_en;
      if (w_dbg_grant && !dbg_wr_en) begin
        r_dbg_rdata <= mem_data_out;
      end
    end
  end

  always_comb begin
    w_cpu_grant  = 1'b0;
    w_dbg_grant  = 1'b0;
    w_st_next    = r_st;
    w_burst_next = r_burst_cnt;
    w_wait_next  = r_wait_cnt;

    case (r_st)
      CPU_OWN: begin
        w_cpu_grant  = cpu_req;
        w_dbg_grant  = dbg_valid && !cpu_req;
        w_burst_next = '0;
        if (dbg_valid && !w_dbg_grant && (r_wait_cnt == WAIT_LAST)) begin
          w_st_next = DBG_OWN;
        end
      end
      DBG_OWN: begin
        w_dbg_grant = dbg_valid;
        w_cpu_grant = cpu_req && !dbg_valid;
        // Debug releasing the port early ends the period regardless of count.
        if (!dbg_valid) begin
          w_st_next    = CPU_OWN;
          w_burst_next = '0;
        end else if (r_burst_cnt == BURST_LAST) begin
          w_st_next    = CPU_OWN;
          w_burst_next = '0;
        end else begin
          w_burst_next = r_burst_cnt + 1'b1;
        end
      end
      default: begin
        w_st_next    = CPU_OWN;
        w_burst_next = '0;
      end
    endcase

    if (w_dbg_grant || !dbg_valid) begin
      w_wait_next = '0;
    end else if (r_wait_cnt != WAIT_MAX) begin
      w_wait_next = r_wait_cnt + 1'b1;
    end
  end

  always_comb begin
    mem_wr_en   = 1'b0;
    mem_op      = cpu_op;
    mem_addr    = '0;
    mem_data_in = '0;
    if (w_cpu_grant) begin
      mem_wr_en   = cpu_wr_en;
      mem_addr    = cpu_addr;
      mem_data_in = cpu_wdata;
    end else if (w_dbg_grant) begin
      mem_wr_en   = dbg_wr_en;
      mem_op      = dbg_op;
      mem_addr    = dbg_addr;
      mem_data_in = dbg_wdata;
    end
  end

  assign cpu_rdata  = mem_data_out;
  assign cpu_stall  = cpu_req && !w_cpu_grant;
  assign dbg_ready  = w_dbg_grant;
  assign dbg_rdata  = r_dbg_rdata;
  assign dbg_rvalid = r_dbg_rvalid;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int SL = 4;
  localparam int MB = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_wr_en;
  mem_op_t     cpu_op;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dbg_valid, dbg_ready, dbg_wr_en;
  mem_op_t     dbg_op;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        dbg_rvalid;
  logic        mem_wr_en;
  mem_op_t     mem_op;
  logic [31:0] mem_addr, mem_data_in, mem_data_out;

  dmem_arbiter #(.STARVE_LIMIT(SL), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr_en(cpu_wr_en), .cpu_op(cpu_op),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_wr_en(dbg_wr_en),
    .dbg_op(dbg_op), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .mem_wr_en(mem_wr_en), .mem_op(mem_op), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Word-wide stand-in for data_memory: combinational read, write at the edge.
  logic [31:0] mem [0:1023];
  assign mem_data_out = mem[mem_addr[11:2]];
  always @(posedge clk) if (mem_wr_en === 1'b1) mem[mem_addr[11:2]] <= mem_data_in;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who gets the port, and how long debug has been waiting.
  bit          m_valid = 0;
  bit          m_dbg_own;
  int          m_streak;
  int          m_grants;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  always @(negedge clk) begin : model
    logic        eg_d, eg_c, e_wr;
    logic [31:0] e_addr, e_din;
    mem_op_t     e_op;
    eg_d = 1'b0;
    if (m_valid) begin
      eg_d   = dbg_valid && (m_dbg_own || !cpu_req);
      eg_c   = cpu_req && !eg_d;
      e_wr   = eg_c ? cpu_wr_en : (eg_d ? dbg_wr_en : 1'b0);
      e_addr = eg_c ? cpu_addr  : (eg_d ? dbg_addr  : 32'h0);
      e_din  = eg_c ? cpu_wdata : (eg_d ? dbg_wdata : 32'h0);
      e_op   = eg_d ? dbg_op : cpu_op;
      check("cpu_stall",   {31'h0, cpu_stall}, {31'h0, cpu_req && !eg_c});
      check("dbg_ready",   {31'h0, dbg_ready}, {31'h0, eg_d});
      check("mem_wr_en",   {31'h0, mem_wr_en}, {31'h0, e_wr});
      check("mem_op",      {29'h0, mem_op},    {29'h0, e_op});
      check("mem_addr",    mem_addr,           e_addr);
      check("mem_data_in", mem_data_in,        e_din);
      check("cpu_rdata",   cpu_rdata,          mem[e_addr[11:2]]);
      check("dbg_rvalid",  {31'h0, dbg_rvalid}, {31'h0, m_rvalid});
      check("dbg_rdata",   dbg_rdata,          m_rdata);
    end
    if (reset) begin
      m_valid   = 1;
      m_dbg_own = 0;
      m_streak  = 0;
      m_grants  = 0;
      m_rvalid  = 0;
      m_rdata   = 0;
    end else if (m_valid) begin
      m_rvalid = eg_d && !dbg_wr_en;
      if (m_rvalid) m_rdata = mem[dbg_addr[11:2]];
      if (eg_d || !dbg_valid) m_streak = 0;
      else m_streak++;
      if (!m_dbg_own) begin
        if (m_streak == SL) begin
          m_dbg_own = 1;
          m_grants  = 0;
          m_streak  = 0;
        end
      end else if (!dbg_valid) begin
        m_dbg_own = 0;
      end else begin
        m_grants++;
        if (m_grants == MB) m_dbg_own = 0;
      end
    end
  end

  logic [31:0] rdy_bits, stl_bits, rv_bits;
  int          pidx;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pat();
    rdy_bits = 0; stl_bits = 0; rv_bits = 0; pidx = 0;
  endtask

  task automatic pat(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rdy_bits[pidx] = dbg_ready;
      stl_bits[pidx] = cpu_stall;
      rv_bits[pidx]  = dbg_rvalid;
      pidx++;
      next_cycle();
    end
  endtask

  function automatic mem_op_t rand_op();
    case ($urandom_range(0, 4))
      0: return MEM_B;
      1: return MEM_H;
      2: return MEM_W;
      3: return MEM_BU;
      default: return MEM_HU;
    endcase
  endfunction

  initial begin
    logic rdy_seen;
    int   busy;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    reset = 1; cpu_req = 0; cpu_wr_en = 0; cpu_op = MEM_W; cpu_addr = 0; cpu_wdata = 0;
    dbg_valid = 0; dbg_wr_en = 0; dbg_op = MEM_W; dbg_addr = 0; dbg_wdata = 0;
    next_cycle();
    next_cycle();
    reset = 0;
    @(negedge clk);
    check("rst_rvalid", {31'h0, dbg_rvalid}, 32'h0);
    check("rst_rdata",  dbg_rdata, 32'h0);
    check("rst_stall",  {31'h0, cpu_stall}, 32'h0);
    next_cycle();

    // CPU only: store then load
    cpu_req = 1; cpu_wr_en = 1; cpu_op = MEM_W; cpu_addr = 32'h200; cpu_wdata = 32'h0A;
    @(negedge clk);
    check("cpu_st_stall", {31'h0, cpu_stall}, 32'h0);
    check("cpu_st_wr",    {31'h0, mem_wr_en}, 32'h1);
    next_cycle();
    cpu_wr_en = 0;
    @(negedge clk);
    check("cpu_ld_stall", {31'h0, cpu_stall}, 32'h0);
    check("cpu_ld_data",  cpu_rdata, 32'h0000000A);
    check("mem_0x200",    mem[128], 32'h0000000A);
    next_cycle();
    cpu_req = 0;

    // Debug in idle slots: write then read
    dbg_valid = 1; dbg_wr_en = 1; dbg_addr = 32'h100; dbg_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("dbg_wr_ready", {31'h0, dbg_ready}, 32'h1);
    next_cycle();
    dbg_wr_en = 0;
    @(negedge clk);
    check("dbg_rd_ready", {31'h0, dbg_ready}, 32'h1);
    check("dbg_rd_noval", {31'h0, dbg_rvalid}, 32'h0);
    next_cycle();
    dbg_valid = 0;
    @(negedge clk);
    check("dbg_rvalid_1", {31'h0, dbg_rvalid}, 32'h1);
    check("dbg_rdata_1",  dbg_rdata, 32'hDEADBEEF);
    next_cycle();
    @(negedge clk);
    check("dbg_rvalid_pulse", {31'h0, dbg_rvalid}, 32'h0);
    next_cycle();

    // Starvation: grants on cycles 4 and 5 only
    cpu_req = 1; dbg_valid = 1; dbg_wr_en = 0; dbg_addr = 32'h100;
    clear_pat();
    pat(8);
    check("starve_ready", rdy_bits, 32'h30);
    check("starve_stall", stl_bits, 32'h30);
    cpu_req = 0; dbg_valid = 0;
    pat(2);

    // Early exit after one grant, then a fresh wait of four denied cycles
    cpu_req = 1; dbg_valid = 1;
    clear_pat();
    pat(5);
    dbg_valid = 0;
    pat(1);
    dbg_valid = 1;
    pat(5);
    check("early_ready", rdy_bits, 32'h410);
    check("early_stall", stl_bits, 32'h410);
    cpu_req = 0; dbg_valid = 0;
    pat(2);

    // Reset in the first DBG_OWN cycle during a read
    cpu_req = 1; dbg_valid = 1; dbg_wr_en = 0;
    clear_pat();
    pat(4);
    reset = 1;
    pat(1);
    reset = 0;
    pat(5);
    check("rstb_ready",  rdy_bits, 32'h210);
    check("rstb_rvalid", rv_bits,  32'h0);
    cpu_req = 0; dbg_valid = 0;
    pat(2);

    // Request drop restarts the wait
    cpu_req = 1;
    clear_pat();
    dbg_valid = 1;
    pat(3);
    dbg_valid = 0;
    pat(1);
    dbg_valid = 1;
    pat(5);
    check("drop_ready", rdy_bits, 32'h100);
    cpu_req = 0; dbg_valid = 0;
    pat(2);

    // Randomized traffic against the model
    busy = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rdy_seen = dbg_ready;
      next_cycle();
      if (c % 64 == 0) busy = $urandom_range(0, 1);
      cpu_req   = (busy != 0) ? ($urandom_range(0, 99) < 95) : ($urandom_range(0, 99) < 50);
      cpu_wr_en = $urandom_range(0, 1);
      cpu_op    = rand_op();
      cpu_addr  = $urandom;
      cpu_wdata = $urandom;
      if (!dbg_valid || rdy_seen) begin
        dbg_valid = ($urandom_range(0, 99) < 60);
        dbg_wr_en = $urandom_range(0, 1);
        dbg_op    = rand_op();
        dbg_addr  = $urandom;
        dbg_wdata = $urandom;
      end else if ($urandom_range(0, 99) < 3) begin
        dbg_valid = 0;
      end
      reset = ($urandom_range(0, 299) == 0);
    end
    reset = 0;
    @(negedge clk);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
